// File: rtl/wb_mem_arbiter_pkg.sv
// Shared definitions for the cache-to-memory arbiter: FSM state encoding
// and the encoding of the round-robin "last granted" bit.
package wb_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_DCACHE = 2'd1,
        ARB_ICACHE = 2'd2,
        ARB_KILL   = 2'd3
    } type_mem_arb_states_e;

    // Encodings of last_grant_ff; icache is the reset value so dcache wins the first tie.
    localparam logic ARB_GNT_DCACHE = 1'b0;
    localparam logic ARB_GNT_ICACHE = 1'b1;

endpackage

// File: rtl/wb_mem_arbiter.sv
// Two-requester memory-port arbiter (write-back dcache vs. icache).
// Grants one cache per whole line transaction, steers the latched request
// to memory, returns ack only to the owner and turns owner aborts into a
// single-cycle kill pulse towards memory.
module wb_mem_arbiter
    import wb_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              dcache2arb_req_i,
    input  logic              dcache2arb_wr_i,
    input  logic [ADDR_W-1:0] dcache2arb_addr_i,
    input  logic [LINE_W-1:0] dcache2arb_wdata_i,
    input  logic              dcache2arb_kill_i,
    output logic              arb2dcache_ack_o,
    input  logic              icache2arb_req_i,
    input  logic [ADDR_W-1:0] icache2arb_addr_i,
    input  logic              icache2arb_kill_i,
    output logic              arb2icache_ack_o,
    output logic [LINE_W-1:0] arb2cache_rdata_o,
    output logic              arb2mem_req_o,
    output logic              arb2mem_wr_o,
    output logic [ADDR_W-1:0] arb2mem_addr_o,
    output logic [LINE_W-1:0] arb2mem_wdata_o,
    output logic              arb2mem_kill_o,
    input  logic              mem2arb_ack_i,
    input  logic [LINE_W-1:0] mem2arb_rdata_i
);

    type_mem_arb_states_e state_ff, state_d;
    logic                 last_grant_ff, last_grant_d;
    logic [ADDR_W-1:0]    addr_ff, addr_d;
    logic                 wr_ff, wr_d;
    logic [LINE_W-1:0]    wdata_ff, wdata_d;

    // A request only counts when its own kill is low.
    logic dcache_valid, icache_valid;
    assign dcache_valid = dcache2arb_req_i & ~dcache2arb_kill_i;
    assign icache_valid = icache2arb_req_i & ~icache2arb_kill_i;

    // State register and transaction latches.
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_ff      <= ARB_IDLE;
            last_grant_ff <= ARB_GNT_ICACHE;
            addr_ff       <= '0;
            wr_ff         <= 1'b0;
            wdata_ff      <= '0;
        end else begin
            state_ff      <= state_d;
            last_grant_ff <= last_grant_d;
            addr_ff       <= addr_d;
            wr_ff         <= wr_d;
            wdata_ff      <= wdata_d;
        end
    end

    // Next-state logic: round-robin grant in idle, completion/abort while owned.
    always_comb begin
        // NOTE: hold-by-default for every target prevents latch inference.
        state_d      = state_ff;
        last_grant_d = last_grant_ff;
        addr_d       = addr_ff;
        wr_d         = wr_ff;
        wdata_d      = wdata_ff;

        unique case (state_ff)
            ARB_IDLE: begin
                if (dcache_valid && (!icache_valid || last_grant_ff == ARB_GNT_ICACHE)) begin
                    state_d      = ARB_DCACHE;
                    last_grant_d = ARB_GNT_DCACHE;
                    addr_d       = dcache2arb_addr_i;
                    wr_d         = dcache2arb_wr_i;
                    wdata_d      = dcache2arb_wdata_i;
                end else if (icache_valid) begin
                    state_d      = ARB_ICACHE;
                    last_grant_d = ARB_GNT_ICACHE;
                    addr_d       = icache2arb_addr_i;
                    wr_d         = 1'b0;
                    wdata_d      = '0;
                end
            end
            ARB_DCACHE: begin
                // Ack has priority over a simultaneous abort.
                if (mem2arb_ack_i) begin
                    state_d = ARB_IDLE;
                end else if (dcache2arb_kill_i || !dcache2arb_req_i) begin
                    state_d = ARB_KILL;
                end
            end
            ARB_ICACHE: begin
                if (mem2arb_ack_i) begin
                    state_d = ARB_IDLE;
                end else if (icache2arb_kill_i || !icache2arb_req_i) begin
                    state_d = ARB_KILL;
                end
            end
            ARB_KILL: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Outputs: memory side from registered state only; acks gated by ownership.
    always_comb begin
        arb2mem_req_o     = 1'b0;
        arb2mem_wr_o      = 1'b0;
        arb2mem_kill_o    = 1'b0;
        arb2dcache_ack_o  = 1'b0;
        arb2icache_ack_o  = 1'b0;
        arb2mem_addr_o    = addr_ff;
        arb2mem_wdata_o   = wdata_ff;
        arb2cache_rdata_o = mem2arb_rdata_i;

        unique case (state_ff)
            ARB_DCACHE: begin
                arb2mem_req_o    = 1'b1;
                arb2mem_wr_o     = wr_ff;
                arb2dcache_ack_o = mem2arb_ack_i;
            end
            ARB_ICACHE: begin
                arb2mem_req_o    = 1'b1;
                arb2mem_wr_o     = wr_ff;
                arb2icache_ack_o = mem2arb_ack_i;
            end
            ARB_KILL: begin
                arb2mem_kill_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: a transaction-level ownership
// model checked against the DUT every negedge, plus directed literal checks.
module tb_wb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              d_req = 0, d_wr = 0, d_kill = 0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [LINE_W-1:0] d_wdata = '0;
    logic              i_req = 0, i_kill = 0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              m_ack = 0;
    logic [LINE_W-1:0] m_rdata = '0;

    logic              d_ack, i_ack, mem_req, mem_wr, mem_kill;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata, c_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    wb_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .dcache2arb_req_i   (d_req),
        .dcache2arb_wr_i    (d_wr),
        .dcache2arb_addr_i  (d_addr),
        .dcache2arb_wdata_i (d_wdata),
        .dcache2arb_kill_i  (d_kill),
        .arb2dcache_ack_o   (d_ack),
        .icache2arb_req_i   (i_req),
        .icache2arb_addr_i  (i_addr),
        .icache2arb_kill_i  (i_kill),
        .arb2icache_ack_o   (i_ack),
        .arb2cache_rdata_o  (c_rdata),
        .arb2mem_req_o      (mem_req),
        .arb2mem_wr_o       (mem_wr),
        .arb2mem_addr_o     (mem_addr),
        .arb2mem_wdata_o    (mem_wdata),
        .arb2mem_kill_o     (mem_kill),
        .mem2arb_ack_i      (m_ack),
        .mem2arb_rdata_i    (m_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: 0 = nobody, 1 = dcache, 2 = icache, 3 = abort in progress
    int                owner = 0;
    bit                dcache_won_last = 0;
    logic [ADDR_W-1:0] mdl_addr = '0;
    logic              mdl_wr = 0;
    logic [LINE_W-1:0] mdl_wdata = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            owner = 0; dcache_won_last = 0;
            mdl_addr = '0; mdl_wr = 0; mdl_wdata = '0;
        end else if (owner == 0) begin
            bit dv, iv, pick_d;
            dv = d_req && !d_kill;
            iv = i_req && !i_kill;
            pick_d = dv && (!iv || !dcache_won_last);
            if (pick_d) begin
                owner = 1; dcache_won_last = 1;
                mdl_addr = d_addr; mdl_wr = d_wr; mdl_wdata = d_wdata;
            end else if (iv) begin
                owner = 2; dcache_won_last = 0;
                mdl_addr = i_addr; mdl_wr = 0; mdl_wdata = '0;
            end
        end else if (owner == 3) begin
            owner = 0;
        end else begin
            bit own_req, own_kill;
            own_req  = (owner == 1) ? d_req  : i_req;
            own_kill = (owner == 1) ? d_kill : i_kill;
            if (m_ack) owner = 0;
            else if (own_kill || !own_req) owner = 3;
        end
    end

    // Compare the DUT with the model on every falling edge.
    always @(negedge clk) begin
        bit busy;
        busy = (owner == 1) || (owner == 2);
        check("cmp_req",   LINE_W'(mem_req),  LINE_W'(busy));
        check("cmp_wr",    LINE_W'(mem_wr),   LINE_W'(busy && mdl_wr));
        check("cmp_kill",  LINE_W'(mem_kill), LINE_W'(owner == 3));
        check("cmp_dack",  LINE_W'(d_ack),    LINE_W'(owner == 1 && m_ack));
        check("cmp_iack",  LINE_W'(i_ack),    LINE_W'(owner == 2 && m_ack));
        check("cmp_addr",  LINE_W'(mem_addr), LINE_W'(mdl_addr));
        check("cmp_wdata", mem_wdata,         mdl_wdata);
        check("cmp_rdata", c_rdata,           m_rdata);
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    localparam logic [ADDR_W-1:0] A_D0 = 32'h8000_0040;
    localparam logic [ADDR_W-1:0] A_I0 = 32'h0000_1000;
    localparam logic [LINE_W-1:0] L_A5 = {16{8'hA5}};
    localparam logic [LINE_W-1:0] L_12 = {8{16'h1234}};

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   LINE_W'(mem_req),  '0);
        check("rst_wr",    LINE_W'(mem_wr),   '0);
        check("rst_kill",  LINE_W'(mem_kill), '0);
        check("rst_addr",  LINE_W'(mem_addr), '0);
        check("rst_wdata", mem_wdata,         '0);
        rst = 0;

        // Tie after reset: dcache first, then icache, then dcache again
        cyc();
        d_req = 1; d_addr = A_D0; i_req = 1; i_addr = A_I0;
        cyc();
        check("tie1_req",  LINE_W'(mem_req),  1);
        check("tie1_addr", LINE_W'(mem_addr), LINE_W'(A_D0));
        m_ack = 1; m_rdata = 128'h11;
        #1;
        check("tie1_dack", LINE_W'(d_ack), 1);
        check("tie1_iack", LINE_W'(i_ack), 0);
        cyc();
        d_req = 0; m_ack = 0;
        #1;
        check("tie_gap_req", LINE_W'(mem_req), 0);
        cyc();
        check("tie2_req",  LINE_W'(mem_req),  1);
        check("tie2_addr", LINE_W'(mem_addr), LINE_W'(A_I0));
        check("tie2_wr",   LINE_W'(mem_wr),   0);
        m_ack = 1;
        #1;
        check("tie2_iack", LINE_W'(i_ack), 1);
        check("tie2_dack", LINE_W'(d_ack), 0);
        cyc();
        m_ack = 0; d_req = 1; i_req = 1;
        cyc();
        check("tie3_addr", LINE_W'(mem_addr), LINE_W'(A_D0));
        m_ack = 1;
        cyc();
        m_ack = 0; d_req = 0; i_req = 0;
        cyc();

        // dcache-only allocate with ack three cycles after grant
        d_req = 1; d_wr = 0; d_addr = A_D0;
        #1;
        check("alloc_req_n", LINE_W'(mem_req), 0);
        cyc();
        check("alloc_req_n1", LINE_W'(mem_req), 1);
        repeat (3) cyc();
        m_ack = 1; m_rdata = L_A5;
        #1;
        check("alloc_dack",  LINE_W'(d_ack), 1);
        check("alloc_rdata", c_rdata,        L_A5);
        check("alloc_iack",  LINE_W'(i_ack), 0);
        cyc();
        m_ack = 0; d_req = 0;
        cyc();

        // dcache write-back: latched wdata stays while the input changes
        d_req = 1; d_wr = 1; d_addr = 32'h0000_2000; d_wdata = L_12;
        cyc();
        check("wb_wr",    LINE_W'(mem_wr), 1);
        check("wb_wdata", mem_wdata,       L_12);
        d_wdata = ~L_12;
        repeat (2) cyc();
        check("wb_wdata_hold", mem_wdata, L_12);
        m_ack = 1;
        #1;
        check("wb_dack", LINE_W'(d_ack), 1);
        cyc();
        m_ack = 0; d_req = 0; d_wr = 0;
        cyc();

        // icache kill two cycles into a fill; pending dcache served afterwards
        i_req = 1; i_addr = 32'h0000_3000; d_req = 1; d_addr = 32'h0000_4000;
        cyc();
        check("kill_own_addr", LINE_W'(mem_addr), 32'h0000_3000);
        cyc();
        i_kill = 1;
        #1;
        check("kill_req_hold", LINE_W'(mem_req), 1);
        cyc();
        check("kill_req_drop", LINE_W'(mem_req),  0);
        check("kill_pulse",    LINE_W'(mem_kill), 1);
        check("kill_iack",     LINE_W'(i_ack),    0);
        i_kill = 0; i_req = 0;
        cyc();
        check("kill_pulse_end", LINE_W'(mem_kill), 0);
        cyc();
        check("kill_next_req",  LINE_W'(mem_req),  1);
        check("kill_next_addr", LINE_W'(mem_addr), 32'h0000_4000);
        m_ack = 1;
        cyc();
        m_ack = 0; d_req = 0;
        cyc();

        // Kill and ack in the same cycle: ack wins
        d_req = 1; d_addr = 32'h0000_5000;
        repeat (2) cyc();
        d_kill = 1; m_ack = 1;
        #1;
        check("race_dack", LINE_W'(d_ack), 1);
        cyc();
        d_kill = 0; m_ack = 0; d_req = 0;
        check("race_nokill", LINE_W'(mem_kill), 0);
        cyc();
        check("race_nokill2", LINE_W'(mem_kill), 0);

        // Asynchronous reset mid write-back
        d_req = 1; d_wr = 1; d_addr = 32'h0000_6000; d_wdata = L_12;
        cyc();
        check("ar_req_before", LINE_W'(mem_req), 1);
        #2;
        rst = 1;
        #1;
        check("ar_req",   LINE_W'(mem_req),  0);
        check("ar_wr",    LINE_W'(mem_wr),   0);
        check("ar_addr",  LINE_W'(mem_addr), 0);
        check("ar_wdata", mem_wdata,         0);
        check("ar_kill",  LINE_W'(mem_kill), 0);
        cyc();
        rst = 0; d_wr = 0; d_addr = 32'h0000_7000;
        cyc();
        check("ar_regrant",      LINE_W'(mem_req),  1);
        check("ar_regrant_addr", LINE_W'(mem_addr), 32'h0000_7000);
        m_ack = 1;
        #1;
        check("ar_dack", LINE_W'(d_ack), 1);
        cyc();
        m_ack = 0; d_req = 0;
        repeat (2) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
